comp_strg_arb: RTL

Round-robin command arbiter and sequencer in front of `comp_strg`, sharing the single computation-storage port between NREQ requesters. It accepts one command at a time over a valid/ready handshake and drives `comp_strg` en/cmd/addresses/DQ for one cycle. It then waits for completion (`valid_out` for reads, a fixed latency otherwise) and returns one tagged response per command. Only one command is outstanding at a time.

---
 rtl/comp_strg_arb_if.sv | 58 +++++
 rtl/comp_strg_arb.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/comp_strg_arb_if.sv
// Bus bundles around the comp_strg arbiter: requester-side command/response
// channel and the single comp_strg access port.

interface comp_strg_arb_req_if #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [2*NREQ-1:0]          req_cmd;
  logic [ADDR_WIDTH*NREQ-1:0] req_addA;
  logic [ADDR_WIDTH*NREQ-1:0] req_addB;
  logic [ADDR_WIDTH*NREQ-1:0] req_addC;
  logic [DATA_WIDTH*NREQ-1:0] req_wdata;
  logic                       rsp_valid;
  logic [IDW-1:0]             rsp_id;
  logic [DATA_WIDTH-1:0]      rsp_data;
  logic                       rsp_err;
  logic                       busy;

  modport master (
    output req_valid, req_cmd, req_addA, req_addB, req_addC, req_wdata,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_cmd, req_addA, req_addB, req_addC, req_wdata,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

interface comp_strg_arb_cs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  cs_en;
  logic [1:0]            cs_cmd;
  logic [ADDR_WIDTH-1:0] cs_addA;
  logic [ADDR_WIDTH-1:0] cs_addB;
  logic [ADDR_WIDTH-1:0] cs_addC;
  logic [DATA_WIDTH-1:0] cs_dq_out;
  logic                  cs_dq_oe;
  logic [DATA_WIDTH-1:0] cs_dq_in;
  logic                  cs_valid_out;

  modport master (
    output cs_en, cs_cmd, cs_addA, cs_addB, cs_addC, cs_dq_out, cs_dq_oe,
    input  cs_dq_in, cs_valid_out
  );

  modport slave (
    input  cs_en, cs_cmd, cs_addA, cs_addB, cs_addC, cs_dq_out, cs_dq_oe,
    output cs_dq_in, cs_valid_out
  );
endinterface

// File: rtl/comp_strg_arb.sv
// Round-robin arbiter/sequencer sharing one comp_strg port between NREQ
// requesters; one command outstanding, one tagged response per command.
//
// state | meaning
// IDLE  | arbitrate, accept one command, latch payload
// ISSUE | drive cs_en (and DQ for writes) for one cycle
// WAIT  | read: wait for cs_valid_out or timeout; others: fixed latency
// RESP  | one-cycle response strobe

module comp_strg_arb #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OP_LAT     = 1,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  comp_strg_arb_req_if.slave    req,
  comp_strg_arb_cs_if.master    cs
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [1:0] CMD_RD = 2'b00;
  localparam logic [1:0] CMD_WR = 2'b01;
  localparam logic [7:0] RD_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] OP_LAST = 8'(OP_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state;
  logic [IDW-1:0]         last_grant;
  logic [IDW-1:0]         cur_id;
  logic [7:0]             wait_cnt;

  logic                   grant_any;
  logic [IDW-1:0]         grant_id;
  logic [NREQ-1:0]        grant_oh;
  logic [1:0]             sel_cmd;
  logic [ADDR_WIDTH-1:0]  sel_addA;
  logic [ADDR_WIDTH-1:0]  sel_addB;
  logic [ADDR_WIDTH-1:0]  sel_addC;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  // Search starts just past the previous winner so every requester gets a turn.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && req.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  assign grant_oh  = grant_any ? (NREQ'(1) << grant_id) : '0;
  assign sel_cmd   = req.req_cmd[grant_id*2 +: 2];
  assign sel_addA  = req.req_addA[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_addB  = req.req_addB[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_addC  = req.req_addC[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req.req_wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];

  // The accept pulse is only meaningful while IDLE and out of reset.
  assign req.req_ready = (state == IDLE && rst) ? grant_oh : '0;
  assign req.busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last_grant    <= IDW'(NREQ - 1);
      cur_id        <= '0;
      wait_cnt      <= '0;
      req.rsp_valid <= 1'b0;
      req.rsp_id    <= '0;
      req.rsp_data  <= '0;
      req.rsp_err   <= 1'b0;
      cs.cs_en      <= 1'b0;
      cs.cs_cmd     <= '0;
      cs.cs_addA    <= '0;
      cs.cs_addB    <= '0;
      cs.cs_addC    <= '0;
      cs.cs_dq_out  <= '0;
      cs.cs_dq_oe   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            cur_id       <= grant_id;
            last_grant   <= grant_id;
            cs.cs_cmd    <= sel_cmd;
            cs.cs_addA   <= sel_addA;
            cs.cs_addB   <= sel_addB;
            cs.cs_addC   <= sel_addC;
            cs.cs_en     <= 1'b1;
            cs.cs_dq_oe  <= (sel_cmd == CMD_WR);
            cs.cs_dq_out <= (sel_cmd == CMD_WR) ? sel_wdata : '0;
            state        <= ISSUE;
          end
        end

        ISSUE: begin
          cs.cs_en     <= 1'b0;
          cs.cs_dq_oe  <= 1'b0;
          cs.cs_dq_out <= '0;
          wait_cnt     <= '0;
          state        <= WAIT;
        end

        WAIT: begin
          if (cs.cs_cmd == CMD_RD) begin
            // A valid_out on the last allowed cycle still wins over the timeout.
            if (cs.cs_valid_out) begin
              req.rsp_valid <= 1'b1;
              req.rsp_id    <= cur_id;
              req.rsp_data  <= cs.cs_dq_in;
              req.rsp_err   <= 1'b0;
              state         <= RESP;
            end else if (wait_cnt == RD_LAST) begin
              req.rsp_valid <= 1'b1;
              req.rsp_id    <= cur_id;
              req.rsp_data  <= '0;
              req.rsp_err   <= 1'b1;
              state         <= RESP;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end else begin
            if (wait_cnt == OP_LAST) begin
              req.rsp_valid <= 1'b1;
              req.rsp_id    <= cur_id;
              req.rsp_data  <= '0;
              req.rsp_err   <= 1'b0;
              state         <= RESP;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
        end

        RESP: begin
          req.rsp_valid <= 1'b0;
          req.rsp_data  <= '0;
          req.rsp_err   <= 1'b0;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
